// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared definitions for the pipeline control blocks.
//                - interrupt-entry FSM state encoding
//                - default mult/div busy-cycle counts
//                - register hazard match helper
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

  typedef enum logic [1:0] {
    INT_IDLE  = 2'd0,
    INT_FLUSH = 2'd1,
    INT_DRAIN = 2'd2
  } int_state_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Register $0 is hard-wired to zero, so it can never carry a dependency.
  function automatic logic reg_match(
    input logic [4:0] r,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       use_rs,
    input logic       use_rt
  );
    return (r != 5'd0) && ((use_rs && (r == rs)) || (use_rt && (r == rt)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_busy_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : md_busy_cnt
//  Description : Loadable down-counter tracking the multi-cycle mult/div unit.
//  Ports       : clk, rst (sync, active-low)
//                md_start  - mult/div issued this cycle
//                md_div    - 1 = div, 0 = mult (qualifies md_start)
//                md_busy   - unit busy (count nonzero)
//  Revision    : 1.0  initial release
// ============================================================================
module md_busy_cnt #(
  parameter int MULT_CYCLES = cpu_pkg::MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = cpu_pkg::DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start,
  input  logic md_div,
  output logic md_busy
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [CNT_W-1:0] md_cnt;

  // A new issue is accepted only when idle; an issue while counting is
  // dropped so the running count is never stretched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      md_cnt <= '0;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - ONE;
    end else if (md_start) begin
      md_cnt <= md_div ? DIV_LOAD : MULT_LOAD;
    end
  end

  assign md_busy = (md_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Stall/flush sequencer for the 5-stage pipeline.
//                Detects load-use, mfc0-use, branch-operand and HI/LO
//                hazards, tracks the mult/div unit and sequences
//                interrupt entry.
//  Ports       : clk, rst (sync, active-low)
//                id_*  - ID-stage operand usage / instruction class
//                ex_*  - EX-stage writer info
//                mem_* - MEM-stage writer info
//                md_start, md_div - mult/div issue
//                int_req          - CP0 interrupt request (level)
//                stall, bubble    - hold PC+IF/ID, zero ID/EX control
//                int_flush, pc_sel_exc - interrupt entry flush / vector select
//                md_busy          - mult/div in progress
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_branch,
  input  logic       id_md,
  input  logic [4:0] ex_wreg,
  input  logic       ex_regwrite,
  input  logic       ex_load,
  input  logic       ex_mfc0,
  input  logic       ex_alu_wr,
  input  logic [4:0] mem_wreg,
  input  logic       mem_load,
  input  logic       md_start,
  input  logic       md_div,
  input  logic       int_req,
  output logic       stall,
  output logic       bubble,
  output logic       int_flush,
  output logic       pc_sel_exc,
  output logic       md_busy
);

  int_state_t int_state;
  logic       flush_q;
  logic       ex_match;
  logic       mem_match;
  logic       hazard;

  md_busy_cnt #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_cnt (
    .clk      (clk),
    .rst      (rst),
    .md_start (md_start),
    .md_div   (md_div),
    .md_busy  (md_busy)
  );

  assign ex_match  = reg_match(ex_wreg,  id_rs, id_rt, id_use_rs, id_use_rt);
  assign mem_match = reg_match(mem_wreg, id_rs, id_rt, id_use_rs, id_use_rt);

  // Branches resolve in ID, so they also wait on ALU results in EX and on
  // loads still in MEM; ordinary consumers get those values by forwarding.
  assign hazard = (ex_regwrite && (ex_load || ex_mfc0) && ex_match)
               || (id_branch && ex_regwrite && ex_alu_wr && ex_match)
               || (id_branch && mem_load && mem_match)
               || (id_md && (md_busy || md_start));

  // Interrupt entry takes precedence: a pending or in-progress entry
  // suppresses the stall so it can never coincide with the flush.
  assign stall  = hazard && (int_state == INT_IDLE) && !int_req;
  assign bubble = stall;

  // The flush flop is set on the same edge that enters FLUSH, so it is
  // high exactly while the FSM sits in FLUSH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      int_state <= INT_IDLE;
      flush_q   <= 1'b0;
    end else begin
      case (int_state)
        INT_IDLE: begin
          if (int_req) begin
            int_state <= INT_FLUSH;
            flush_q   <= 1'b1;
          end
        end
        INT_FLUSH: begin
          int_state <= INT_DRAIN;
          flush_q   <= 1'b0;
        end
        INT_DRAIN: begin
          flush_q <= 1'b0;
          if (!int_req) begin
            int_state <= INT_IDLE;
          end
        end
        default: begin
          int_state <= INT_IDLE;
          flush_q   <= 1'b0;
        end
      endcase
    end
  end

  assign int_flush  = flush_q;
  assign pc_sel_exc = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Directed self-checking bench for pipe_hazard_ctrl.
//                Outputs are compared as {stall,bubble,int_flush,
//                pc_sel_exc,md_busy}.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_wreg, mem_wreg;
  logic       id_use_rs, id_use_rt, id_branch, id_md;
  logic       ex_regwrite, ex_load, ex_mfc0, ex_alu_wr, mem_load;
  logic       md_start, md_div, int_req;
  logic       stall, bubble, int_flush, pc_sel_exc, md_busy;

  int tests  = 0;
  int failed = 0;

  logic [4:0] obs;
  logic [4:0] exp_v;

  assign obs = {stall, bubble, int_flush, pc_sel_exc, md_busy};

  pipe_hazard_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_branch   (id_branch),
    .id_md       (id_md),
    .ex_wreg     (ex_wreg),
    .ex_regwrite (ex_regwrite),
    .ex_load     (ex_load),
    .ex_mfc0     (ex_mfc0),
    .ex_alu_wr   (ex_alu_wr),
    .mem_wreg    (mem_wreg),
    .mem_load    (mem_load),
    .md_start    (md_start),
    .md_div      (md_div),
    .int_req     (int_req),
    .stall       (stall),
    .bubble      (bubble),
    .int_flush   (int_flush),
    .pc_sel_exc  (pc_sel_exc),
    .md_busy     (md_busy)
  );

  always #5 clk = ~clk;

  // Advance to a point safely after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs;
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_branch = 1'b0; id_md = 1'b0;
    ex_wreg = 5'd0; ex_regwrite = 1'b0; ex_load = 1'b0; ex_mfc0 = 1'b0;
    ex_alu_wr = 1'b0; mem_wreg = 5'd0; mem_load = 1'b0;
    md_start = 1'b0; md_div = 1'b0; int_req = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();
    #1;
    tests++;
    if (obs !== 5'b00000) begin
      failed++;
      $display("FAIL reset_outputs: got %b expected %b", obs, 5'b00000);
    end
    rst = 1'b1;
  endtask

  task automatic test_load_use;
    // lw $8 in EX, addu in ID reads rs=8
    tick(); clear_inputs();
    ex_load = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd8;
    id_use_rs = 1'b1; id_rs = 5'd8;
    #1; tests++;
    if (obs !== 5'b11000) begin
      failed++; $display("FAIL load_use_rs: got %b expected %b", obs, 5'b11000);
    end
    // $0 destination never stalls
    ex_wreg = 5'd0; id_rs = 5'd0;
    #1; tests++;
    if (obs !== 5'b00000) begin
      failed++; $display("FAIL load_use_r0: got %b expected %b", obs, 5'b00000);
    end
    // mfc0 into rt that ID does read
    ex_load = 1'b0; ex_mfc0 = 1'b1; ex_wreg = 5'd12;
    id_use_rs = 1'b0; id_use_rt = 1'b1; id_rt = 5'd12;
    #1; tests++;
    if (obs !== 5'b11000) begin
      failed++; $display("FAIL mfc0_use_rt: got %b expected %b", obs, 5'b11000);
    end
    // same register number but rt not read
    id_use_rt = 1'b0;
    #1; tests++;
    if (obs !== 5'b00000) begin
      failed++; $display("FAIL mfc0_unused_rt: got %b expected %b", obs, 5'b00000);
    end
  endtask

  task automatic test_branch;
    tick(); clear_inputs();
    id_branch = 1'b1; id_use_rt = 1'b1; id_rt = 5'd9;
    ex_regwrite = 1'b1; ex_alu_wr = 1'b1; ex_wreg = 5'd9;
    #1; tests++;
    if (obs !== 5'b11000) begin
      failed++; $display("FAIL branch_alu_ex: got %b expected %b", obs, 5'b11000);
    end
    // ALU writer is forwarded for non-branch consumers
    id_branch = 1'b0;
    #1; tests++;
    if (obs !== 5'b00000) begin
      failed++; $display("FAIL nonbranch_alu_ex: got %b expected %b", obs, 5'b00000);
    end
    id_branch = 1'b1; ex_regwrite = 1'b0; ex_alu_wr = 1'b0; ex_wreg = 5'd0;
    mem_load = 1'b1; mem_wreg = 5'd9;
    #1; tests++;
    if (obs !== 5'b11000) begin
      failed++; $display("FAIL branch_load_mem: got %b expected %b", obs, 5'b11000);
    end
    mem_wreg = 5'd10;
    #1; tests++;
    if (obs !== 5'b00000) begin
      failed++; $display("FAIL branch_nomatch: got %b expected %b", obs, 5'b00000);
    end
  endtask

  task automatic test_md_div;
    tick(); clear_inputs();
    md_start = 1'b1; md_div = 1'b1; id_md = 1'b1;
    #1; tests++;
    if (obs !== 5'b11000) begin
      failed++; $display("FAIL div_c0: got %b expected %b", obs, 5'b11000);
    end
    for (int c = 1; c <= 12; c++) begin
      tick();
      md_start = (c == 3);   // second issue while busy must be ignored
      md_div   = 1'b1;
      #1;
      exp_v = (c <= 10) ? 5'b11001 : 5'b00000;
      tests++;
      if (obs !== exp_v) begin
        failed++; $display("FAIL div_c%0d: got %b expected %b", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_md_mult;
    tick(); clear_inputs();
    md_start = 1'b1; md_div = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      md_start = 1'b0;
      #1;
      exp_v = (c <= 5) ? 5'b00001 : 5'b00000;
      tests++;
      if (obs !== exp_v) begin
        failed++; $display("FAIL mult_c%0d: got %b expected %b", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_int_level;
    // load-use hazard present throughout: stall reappears only back in IDLE
    tick(); clear_inputs();
    ex_load = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd8;
    id_use_rs = 1'b1; id_rs = 5'd8;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) tick();
      int_req = (c <= 4);
      #1;
      if (c == 1)      exp_v = 5'b00110;
      else if (c >= 6) exp_v = 5'b11000;
      else             exp_v = 5'b00000;
      tests++;
      if (obs !== exp_v) begin
        failed++; $display("FAIL int_level_c%0d: got %b expected %b", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_int_hazard;
    tick(); clear_inputs();
    md_start = 1'b1; md_div = 1'b0;          // mult issued, busy cycles 1-5
    for (int c = 1; c <= 6; c++) begin
      tick(); clear_inputs();
      ex_load = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd8;
      id_use_rs = 1'b1; id_rs = 5'd8;
      int_req = (c == 1);
      #1;
      case (c)
        1:       exp_v = 5'b00001;  // request suppresses the stall
        2:       exp_v = 5'b00111;  // flush pulse, mult still counting
        3:       exp_v = 5'b00001;  // drain
        4, 5:    exp_v = 5'b11001;  // back in idle, hazard stalls again
        default: exp_v = 5'b11000;
      endcase
      tests++;
      if (obs !== exp_v) begin
        failed++; $display("FAIL int_hazard_c%0d: got %b expected %b", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid;
    tick(); clear_inputs();
    md_start = 1'b1; md_div = 1'b1; int_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      md_start = 1'b0;
    end
    // count is 6 and FSM is in DRAIN here; reset with busy inputs applied
    #1; tests++;
    if (obs !== 5'b00001) begin
      failed++; $display("FAIL pre_reset_drain: got %b expected %b", obs, 5'b00001);
    end
    rst = 1'b0; md_start = 1'b1; id_md = 1'b0;
    tick();
    rst = 1'b1; clear_inputs();
    #1; tests++;
    if (obs !== 5'b00000) begin
      failed++; $display("FAIL reset_mid_outputs: got %b expected %b", obs, 5'b00000);
    end
    tick();
    // FSM must be idle: a plain load-use hazard stalls, count stays cleared
    ex_load = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd3;
    id_use_rt = 1'b1; id_rt = 5'd3;
    #1; tests++;
    if (obs !== 5'b11000) begin
      failed++; $display("FAIL reset_mid_idle: got %b expected %b", obs, 5'b11000);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_md_div();
    test_md_mult();
    test_int_level();
    test_int_hazard();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Detects load-use and mfc0-use hazards; holds PC and IF/ID and inserts ID/EX bubbles.
- Tracks the multi-cycle mult/div unit so HI/LO consumers wait.
- Sequences interrupt/exception entry by driving the pipeline-register flush lines and the exception PC select.

Parameters:
MULT_CYCLES, 5, busy cycles after a mult/multu issue
DIV_CYCLES, 10, busy cycles after a div/divu issue
CNT_W, 4, mult/div counter width; must hold DIV_CYCLES

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous, active-low reset
id_rs  in  5  ID-stage rs field
id_rt  in  5  ID-stage rt field
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_branch  in  1  ID instruction is a branch/jr/jalr (operands needed in ID)
id_md  in  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo
ex_wreg  in  5  EX-stage destination register
ex_regwrite  in  1  EX instruction writes the register file
ex_load  in  1  EX instruction is a load
ex_mfc0  in  1  EX instruction is mfc0
ex_alu_wr  in  1  EX instruction writes an ALU result
mem_wreg  in  5  MEM-stage destination register
mem_load  in  1  MEM instruction is a load (or mfc0)
md_start  in  1  EX issues a mult/div this cycle
md_div  in  1  qualifies md_start: 1 = div, 0 = mult
int_req  in  1  CP0 interrupt/exception request (level)
stall  out  1  hold PC and IF/ID
bubble  out  1  zero ID/EX control this cycle
int_flush  out  1  IntBeq to IF/ID, ID/EX, EX/MEM
pc_sel_exc  out  1  PC mux selects the exception vector
md_busy  out  1  mult/div in progress

Behaviour:
- Reset (rst=0 at a clk edge): int_state=IDLE, md_cnt=0. All outputs are 0 in the following cycle. A reset taken mid-count aborts the count.
- A hazard "match(r)" requires r != 0 and ((id_use_rs and r==id_rs) or (id_use_rt and r==id_rt)).
- Hazard term h is combinational and is 1 when any of the following holds:
  - ex_regwrite and (ex_load or ex_mfc0) and match(ex_wreg).
  - id_branch and ex_regwrite and ex_alu_wr and match(ex_wreg).
  - id_branch and mem_load and match(mem_wreg).
  - id_md and (md_busy or md_start).
- stall = bubble = h and (int_state==IDLE) and not int_req.
- Mult/div counter:
  - md_start while md_cnt==0 loads MULT_CYCLES or DIV_CYCLES next cycle.
  - md_cnt decrements each cycle while nonzero.
  - md_start while md_cnt!=0 is ignored; the count is not reloaded.
  - md_busy = (md_cnt != 0). It is registered, so it rises 1 cycle after md_start and stays high exactly N cycles.
  - Interrupts do not cancel an in-flight mult/div.
- Interrupt FSM (Moore; outputs decoded from state):
  - IDLE: on int_req=1, go to FLUSH next edge. The hazard stall is suppressed from the cycle int_req is seen.
  - FLUSH: int_flush=1 and pc_sel_exc=1 for exactly one cycle; then go to DRAIN.
  - DRAIN: all outputs 0. Stay while int_req=1 (CP0 clears the request once EXL is set). Return to IDLE when int_req=0.
  - A level request produces exactly one flush pulse.
  - int_req pulses shorter than 1 cycle that are not sampled are lost; this is by design.
- Priority when events coincide: reset > int_flush > stall/bubble. stall and int_flush are never high together.
- Latency:
  - Hazard outputs are combinational, 0 cycles.
  - int_flush asserts 1 cycle after int_req is sampled.
  - md_busy asserts 1 cycle after md_start.

Decomposition:
- Shared package (cpu_pkg): int FSM state encoding (IDLE=2'd0, FLUSH=2'd1, DRAIN=2'd2) and default MULT_CYCLES/DIV_CYCLES constants, reused by the mult/div unit.
- One sub-module, md_busy_cnt: the loadable down-counter with md_busy output. Hazard decode and the FSM stay inline.

Test Plan:
1. lw $8 in EX (ex_load=1, ex_regwrite=1, ex_wreg=8); ID addu reads rs=8 -> stall=bubble=1 that cycle. ex_wreg=0 in the same setup -> stall=0.
2. ID beq reads rt=9; ALU writer in EX with ex_wreg=9 -> stall=1. Same case with mem_load=1, mem_wreg=9 -> stall=1. No match -> stall=0.
3. md_start=1, md_div=1 at cycle 0:
   - md_busy=1 in cycles 1-10, 0 in cycle 11.
   - ID mflo (id_md=1) stalls cycles 0-10 and is released in cycle 11.
   - A second md_start at cycle 3 leaves the count unchanged.
4. int_req held high 5 cycles from cycle 0:
   - int_flush=pc_sel_exc=1 only in cycle 1.
   - State goes IDLE->FLUSH->DRAIN, then IDLE the cycle after int_req falls. No second pulse occurs.
5. Load-use hazard present when int_req rises -> stall=0 in the same cycle; int_flush pulse follows. A mult/div in flight keeps counting.
6. rst=0 asserted with md_cnt=6 and state=DRAIN -> next cycle md_busy=0, state IDLE, all outputs 0. Inputs are ignored while rst=0.
